sram_rw_port_adapter: RTL and testbench

Request/response front-end for single-port behavioural SRAM macros: `data_arrays_0_0_ext` is the primary target, and any RW0-style macro qualifies. It turns a valid/ready request stream into the macro's `RW0_en/RW0_wmode/RW0_addr/RW0_wmask/RW0_wdata` pins. It captures `RW0_rdata` one cycle after each read into a 2-entry response buffer, so consumers may stall without losing data. Optionally it zero-fills the whole array after reset before accepting traffic.

---
 rtl/sram_rw_port_adapter.sv | 152 +++++++++++++++
 tb/tb_sram_rw_port_adapter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_port_adapter.sv
// Valid/ready front-end for an RW0-style single-port SRAM macro with a 2-entry read response buffer.
// Define SRAM_ZERO_INIT_EN to zero-fill the whole array after reset before any request is accepted.
module sram_rw_port_adapter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128,
    parameter int MASK_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

`ifdef SRAM_ZERO_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            init_wr;
`endif

    logic              run;
    logic              accept;
    logic              push;
    logic              pop;
    logic [2:0]        occupancy;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic              init_done_q, init_done_d;

`ifdef SRAM_ZERO_INIT_EN
    // The counter's top bit stops the fill from ever starting a second pass.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_wr = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr = !cnt_q[ADDR_W] && !reset;
                if (init_wr) begin
                    cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (&cnt_q[ADDR_W-1:0]) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: ;
        endcase
    end

    assign run         = (state_q == ST_RUN);
    assign init_done_d = (state_d == ST_RUN);
`else
    assign run         = init_done_q;
    assign init_done_d = 1'b1;
`endif

    // A read needs a buffer slot that is still free when its data lands next cycle.
    assign pop        = (count_q != 2'd0) && resp_ready;
    assign push       = inflight_q;
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign req_ready  = run && (req_write || (occupancy < 3'd2));
    assign accept     = req_valid && req_ready;
    assign resp_valid = (count_q != 2'd0);
    assign resp_rdata = buf_q[rd_ptr_q];
    assign init_done  = init_done_q;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        inflight_d = accept && !req_write;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        buf_d      = buf_q;
        if (push) begin
            buf_d[wr_ptr_q] = sram_rdata;
        end
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (accept) begin
            sram_en    = 1'b1;
            sram_wmode = req_write;
            sram_addr  = req_addr;
            sram_wmask = req_mask;
            sram_wdata = req_wdata;
        end
`ifdef SRAM_ZERO_INIT_EN
        if (init_wr) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = cnt_q[ADDR_W-1:0];
            sram_wmask = '1;
            sram_wdata = '0;
        end
`endif
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            init_done_q <= 1'b0;
            // NOTE: the buffer is reset because its head drives resp_rdata, which must read 0 out of reset.
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
`ifdef SRAM_ZERO_INIT_EN
            state_q     <= ST_INIT;
            cnt_q       <= '0;
`endif
        end else begin
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            init_done_q <= init_done_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
`ifdef SRAM_ZERO_INIT_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_rw_port_adapter.sv
// Directed self-checking bench for sram_rw_port_adapter with a behavioural RW0 SRAM macro model.
// Expected init timing follows SRAM_ZERO_INIT_EN, matching whichever build of the design is compiled.
module tb_sram_rw_port_adapter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 128;
    localparam int MASK_W = 4;
    localparam int LANE_W = DATA_W / MASK_W;

`ifdef SRAM_ZERO_INIT_EN
    localparam int                INIT_CYCLES = 1024;
    localparam logic              INIT_EN     = 1'b1;
    localparam logic [DATA_W-1:0] MEM_FILL    = {4{32'hA5A5_5A5A}};
`else
    localparam int                INIT_CYCLES = 1;
    localparam logic              INIT_EN     = 1'b0;
    localparam logic [DATA_W-1:0] MEM_FILL    = '0;
`endif

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_mask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    sram_rw_port_adapter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MASK_W(MASK_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_mask   (req_mask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port macro: registered read, lane-masked write, read data held across writes.
    logic [DATA_W-1:0] mem [1024] = '{default: MEM_FILL};
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (sram_wmask[l]) mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [MASK_W-1:0] mask,
                      input logic [DATA_W-1:0] data);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_mask  = mask;
        req_wdata = data;
        #1;
        check_bit("wr_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // Read with an empty buffer: data must be at the head two cycles after req_valid rises.
    task automatic read_check(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        #1;
        check_bit({tag, "_ready"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check_bit({tag, "_not_yet"}, resp_valid, 1'b0);
        tick();
        check_bit({tag, "_valid"}, resp_valid, 1'b1);
        check_word({tag, "_data"}, resp_rdata, exp);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_bit({tag, "_drained"}, resp_valid, 1'b0);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_mask   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check_bit("rst_req_ready", req_ready, 1'b0);
        check_bit("rst_resp_valid", resp_valid, 1'b0);
        check_bit("rst_init_done", init_done, 1'b0);
        check_word("rst_resp_rdata", resp_rdata, '0);
        check_bit("rst_sram_en", sram_en, 1'b0);
        check_bit("rst_sram_wmode", sram_wmode, 1'b0);
        check_word("rst_sram_addr", DATA_W'(sram_addr), '0);
        check_word("rst_sram_wmask", DATA_W'(sram_wmask), '0);
        check_word("rst_sram_wdata", sram_wdata, '0);

        // Zero fill (or immediate readiness without it)
        reset = 1'b0;
        #1;
        check_bit("init_pin_en", sram_en, INIT_EN);
        check_bit("init_pin_wmode", sram_wmode, INIT_EN);
        check_word("init_pin_wmask", DATA_W'(sram_wmask), INIT_EN ? DATA_W'(4'hF) : '0);
        check_word("init_pin_addr", DATA_W'(sram_addr), '0);
        wait_init(n);
        check_word("init_cycles", DATA_W'(n), DATA_W'(INIT_CYCLES));
        read_check("zero_0", 10'd0, '0);
        read_check("zero_511", 10'd511, '0);
        read_check("zero_1023", 10'd1023, '0);

        // Masked write then read
        wr(10'h3A, 4'b0101, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA});
        read_check("mask", 10'h3A, {32'h0, 32'hCCCC_CCCC, 32'h0, 32'hAAAA_AAAA});

        // Back-to-back reads with the consumer always ready
        for (int i = 0; i < 8; i++) wr(ADDR_W'(i), 4'hF, DATA_W'(100 + i));
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = ADDR_W'(i);
            #1;
            check_bit("b2b_ready", req_ready, 1'b1);
            tick();
            if (i > 0) begin
                check_bit("b2b_valid", resp_valid, 1'b1);
                check_word("b2b_data", resp_rdata, DATA_W'(100 + i - 1));
            end
        end
        req_valid = 1'b0;
        tick();
        check_bit("b2b_valid_last", resp_valid, 1'b1);
        check_word("b2b_data_last", resp_rdata, DATA_W'(107));
        tick();
        resp_ready = 1'b0;
        check_bit("b2b_drained", resp_valid, 1'b0);

        // Backpressure: two reads fit, then reads stall while writes pass
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'd0;
        #1;
        check_bit("bp_rd0_ready", req_ready, 1'b1);
        tick();
        req_addr = 10'd1;
        #1;
        check_bit("bp_rd1_ready", req_ready, 1'b1);
        tick();
        req_addr = 10'd2;
        #1;
        check_bit("bp_rd2_blocked", req_ready, 1'b0);
        tick();
        #1;
        check_bit("bp_rd2_still_blocked", req_ready, 1'b0);
        req_write = 1'b1;
        req_addr  = 10'h20;
        req_mask  = 4'hF;
        req_wdata = DATA_W'(32'h55);
        #1;
        check_bit("bp_wr_ready", req_ready, 1'b1);
        tick();
        req_write  = 1'b0;
        req_addr   = 10'd2;
        resp_ready = 1'b1;
        #1;
        check_bit("bp_rd2_ready", req_ready, 1'b1);
        check_word("bp_head0", resp_rdata, DATA_W'(100));
        tick();
        req_addr = 10'd3;
        #1;
        check_bit("bp_rd3_ready", req_ready, 1'b1);
        check_word("bp_head1", resp_rdata, DATA_W'(101));
        tick();
        req_valid = 1'b0;
        check_word("bp_head2", resp_rdata, DATA_W'(102));
        tick();
        check_word("bp_head3", resp_rdata, DATA_W'(103));
        tick();
        resp_ready = 1'b0;
        check_bit("bp_drained", resp_valid, 1'b0);
        read_check("bp_write_landed", 10'h20, DATA_W'(32'h55));

        // Ordering hazards on one address
        wr(10'h10, 4'hF, DATA_W'(5));
        wr(10'h10, 4'hF, DATA_W'(9));
        read_check("raw", 10'h10, DATA_W'(9));
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'h10;
        tick();
        req_write = 1'b1;
        req_mask  = 4'hF;
        req_wdata = DATA_W'(7);
        #1;
        check_bit("war_wr_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        check_bit("war_valid", resp_valid, 1'b1);
        check_word("war_data", resp_rdata, DATA_W'(9));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        read_check("war_after", 10'h10, DATA_W'(7));

        // Reset with a full response buffer
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'd0;
        tick();
        req_addr = 10'd1;
        tick();
        req_valid = 1'b0;
        tick();
        check_bit("full_valid", resp_valid, 1'b1);
        #1;
        check_bit("full_ready", req_ready, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_bit("mid_rst_resp_valid", resp_valid, 1'b0);
        check_bit("mid_rst_init_done", init_done, 1'b0);
        #1;
        check_bit("mid_rst_pin_en", sram_en, INIT_EN);
        check_word("mid_rst_pin_addr", DATA_W'(sram_addr), '0);
        wait_init(n);
        check_word("mid_rst_init_cycles", DATA_W'(n), DATA_W'(INIT_CYCLES));
        read_check("mid_rst_addr0", 10'd0, INIT_EN ? '0 : DATA_W'(100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
